saadi_iter_ctrl: RTL

//  Iteration controller that sits directly upstream of the accumulator stage.
//  - Captures an operand and an iteration exponent t.
//  - Drives the accumulator's in1/in2/counter/t inputs for 2^t cycles and

---
 rtl/saadi_pkg.sv | 28 ++
 rtl/saadi_term_shifter.sv | 33 +++
 rtl/saadi_iter_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/saadi_pkg.sv
// Shared types, constants and helpers for the saadi iteration controller.
package saadi_pkg;

    // Default datapath width and the legal range of the iteration exponent.
    localparam int unsigned N_DEFAULT = 8;
    localparam int unsigned T_MIN     = 1;
    localparam int unsigned T_MAX     = N_DEFAULT - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a requested exponent into T_MIN..width-1 so 2^t always fits a width-bit counter.
    function automatic int unsigned clamp_t(input int unsigned t_raw, input int unsigned width);
        int unsigned t_hi;
        t_hi = width - 1;
        if (t_raw < T_MIN) begin
            return T_MIN;
        end
        if (t_raw > t_hi) begin
            return t_hi;
        end
        return t_raw;
    endfunction

endpackage

// File: rtl/saadi_term_shifter.sv
// Combinational barrel shifter producing the current term op >> shamt,
// forced to zero once the shift amount reaches the word width.
module saadi_term_shifter #(
    parameter int n = 8
) (
    input  logic [n-1:0] op,
    input  logic [n-1:0] shamt,
    output logic [n-1:0] term
);

    localparam int LOG = (n > 1) ? $clog2(n) : 1;

    logic [n-1:0] stage [0:LOG];

    assign stage[0] = op;

    // One logarithmic stage per shift-amount bit.
    genvar gi;
    generate
        for (gi = 0; gi < LOG; gi++) begin : g_stage
            assign stage[gi+1] = shamt[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
        end
    endgenerate

    // Any shift of n or more clears the term entirely.
    always_comb begin
        term = '0;
        if (32'(shamt) < n) begin
            term = stage[LOG];
        end
    end

endmodule

// File: rtl/saadi_iter_ctrl.sv
// Iteration controller feeding the accumulator stage: runs 2^t iterations of
// sum <= out_acc while presenting op >> counter as the next term.
module saadi_iter_ctrl
    import saadi_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] op_in,
    input  logic [n-1:0] t_in,
    input  logic [n-1:0] out_acc,
    output logic [n-1:0] in1_acc,
    output logic [n-1:0] in2_acc,
    output logic [n-1:0] counter,
    output logic [n-1:0] t,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    state_t state_reg, state_next;

    logic [n-1:0] op_reg;
    logic [n-1:0] t_reg;
    logic [n-1:0] counter_reg;
    logic [n-1:0] sum_reg;
    logic [n-1:0] result_reg;
    logic [n-1:0] last_idx;
    logic         accept;
    logic         last_iter;

    // Index of the final iteration, (1<<t)-1; t is clamped so this always fits.
    assign last_idx  = n'((32'd1 << t_reg) - 32'd1);
    assign accept    = (state_reg == IDLE) && start;
    assign last_iter = (state_reg == ITER) && (counter_reg == last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ITER;
            ITER:    if (counter_reg == last_idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ITER:    busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Datapath registers: capture on accept, iterate in ITER, latch result on the last pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= '0;
            t_reg       <= '0;
            counter_reg <= '0;
            sum_reg     <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            op_reg      <= op_in;
            t_reg       <= n'(clamp_t(32'(t_in), n));
            counter_reg <= '0;
            sum_reg     <= '0;
        end else if (state_reg == ITER) begin
            if (last_iter) begin
                // Counter parks on the final index so it never exceeds (1<<t)-1.
                result_reg <= out_acc;
            end else begin
                counter_reg <= counter_reg + 1'b1;
                sum_reg     <= out_acc;
            end
        end
    end

    saadi_term_shifter #(.n(n)) u_shifter (
        .op    (op_reg),
        .shamt (counter_reg),
        .term  (in2_acc)
    );

    assign in1_acc = sum_reg;
    assign counter = counter_reg;
    assign t       = t_reg;
    assign result  = result_reg;

endmodule
